uart_cmd_responder: RTL

Robot-side end of the remote command link. It receives 16-bit commands from the remote unit as two 8N1 UART bytes, high byte first. It presents each assembled command to the command processor with a ready flag, and serializes the 8-bit response bytes (acknowledges) back to the remote. It sits between the top-level RX/TX pins and the command processor inside the Knight.

---
 rtl/uart_cmd_responder_pkg.sv | 12 +
 rtl/uart_byte_rx.sv | 90 +++++++++
 rtl/uart_cmd_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// Shared types and framing constants for the remote command link.
package uart_cmd_responder_pkg;

   typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic {RX_IDLE, RX_RECV}  rx_state_t;

   localparam logic [7:0]  POS_ACK    = 8'hA5;
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling, byte/valid/framing-error strobes.
module uart_byte_rx
   import uart_cmd_responder_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 5208
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 byte_vld,
   output logic                 frm_err,
   output logic                 start_det
);

   localparam int unsigned     CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]   HALF     = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0]   FULL     = CW'(BAUD_DIV - 1);
   localparam logic [3:0]      STOP_IDX = 4'(FRAME_BITS - 1);

   logic                 rx_ff1, rx_ff2, rx_prev;
   rx_state_t            state, state_nxt;
   logic [CW-1:0]        baud_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 sample;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ff1  <= 1'b1;
         rx_ff2  <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_ff1  <= rx;
         rx_ff2  <= rx_ff1;
         rx_prev <= rx_ff2;
      end
   end

   assign start_det = (state == RX_IDLE) && rx_prev && !rx_ff2;
   assign sample    = (state == RX_RECV) && (baud_cnt == '0);
   assign rx_byte   = shreg;

   always_comb begin
      state_nxt = state;
      byte_vld  = 1'b0;
      frm_err   = 1'b0;
      case (state)
         RX_IDLE: if (start_det) state_nxt = RX_RECV;
         RX_RECV: begin
            if (sample) begin
               // A high start sample means the edge was a glitch.
               if (bit_cnt == '0 && rx_ff2) begin
                  state_nxt = RX_IDLE;
               end else if (bit_cnt == STOP_IDX) begin
                  state_nxt = RX_IDLE;
                  byte_vld  = rx_ff2;
                  frm_err   = !rx_ff2;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (start_det) begin
         baud_cnt <= HALF;
         bit_cnt  <= '0;
      end else if (state == RX_RECV) begin
         if (baud_cnt == '0) begin
            baud_cnt <= FULL;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt != '0 && bit_cnt != STOP_IDX)
               shreg <= {rx_ff2, shreg[DATA_BITS-1:1]};
         end else begin
            baud_cnt <= baud_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_responder.sv
// Two-byte command assembly from the UART receiver plus the 8N1 response transmitter.
module uart_cmd_responder
   import uart_cmd_responder_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 5208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   localparam int unsigned   CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] FULL     = CW'(BAUD_DIV - 1);
   localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

   logic [7:0] rx_byte;
   logic       byte_vld, frm_err, start_det;

   uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (RX),
      .rx_byte   (rx_byte),
      .byte_vld  (byte_vld),
      .frm_err   (frm_err),
      .start_det (start_det)
   );

   asm_state_t asm_state, asm_nxt;
   logic [7:0] hi_byte;
   logic       set_rdy, clr_rdy;

   always_comb begin
      asm_nxt = asm_state;
      set_rdy = 1'b0;
      clr_rdy = clr_cmd_rdy || (start_det && asm_state == WAIT_HI);
      if (frm_err) begin
         asm_nxt = WAIT_HI;
      end else if (byte_vld) begin
         asm_nxt = (asm_state == WAIT_HI) ? WAIT_LO : WAIT_HI;
         set_rdy = (asm_state == WAIT_LO);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_state <= WAIT_HI;
         hi_byte   <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
      end else begin
         asm_state <= asm_nxt;
         if (byte_vld && asm_state == WAIT_HI) hi_byte <= rx_byte;
         if (set_rdy) cmd <= {hi_byte, rx_byte};
         // Completion wins over a simultaneous clear.
         if (set_rdy)      cmd_rdy <= 1'b1;
         else if (clr_rdy) cmd_rdy <= 1'b0;
      end
   end

   tx_state_t             tx_state, tx_nxt;
   logic [FRAME_BITS-1:0] tx_shreg;
   logic [CW-1:0]         tx_baud;
   logic [3:0]            tx_bit;
   logic                  tx_last;

   assign tx_last = (tx_baud == '0) && (tx_bit == STOP_IDX);
   assign TX      = tx_shreg[0];

   always_comb begin
      tx_nxt = tx_state;
      case (tx_state)
         TX_IDLE:  if (trmt)    tx_nxt = TX_SHIFT;
         TX_SHIFT: if (tx_last) tx_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_nxt;
   end

   // Shifting in ones leaves the line idling high once the frame is out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shreg <= '1;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_done  <= 1'b0;
      end else if (tx_state == TX_IDLE) begin
         if (trmt) begin
            tx_shreg <= {1'b1, resp, 1'b0};
            tx_baud  <= FULL;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
         end
      end else if (tx_baud == '0) begin
         tx_shreg <= {1'b1, tx_shreg[FRAME_BITS-1:1]};
         tx_baud  <= FULL;
         tx_bit   <= tx_bit + 4'd1;
         if (tx_bit == STOP_IDX) tx_done <= 1'b1;
      end else begin
         tx_baud <= tx_baud - 1'b1;
      end
   end

endmodule
